// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the six-stage pipeline (IF, ID, EX1, EX2, MEM, WB).
// Resolves memory wait-states, EX2 branch redirect and load-use hazards; keeps a watchdog and stall counter.
module pipe_hazard_ctrl #(
  parameter int unsigned WAIT_MAX = 255,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       id_rs1,
  input  logic [3:0]       id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [3:0]       ex1_rd,
  input  logic             ex1_is_load,
  input  logic [3:0]       ex2_rd,
  input  logic             ex2_is_load,
  input  logic             ex2_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex1_en,
  output logic             ex1_ex2_en,
  output logic             ex2_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex1_flush,
  output logic             ex1_ex2_flush,
  output logic             mem_wb_bubble,
  output logic [CNT_W-1:0] stall_count,
  output logic             mem_timeout,
  output logic             state_o
);

  localparam logic [0:0]  ST_RUN      = 1'b0;
  localparam logic [0:0]  ST_MEM_WAIT = 1'b1;
  localparam logic [15:0] WAIT_TOP    = 16'(WAIT_MAX);
  localparam logic [15:0] WAIT_LAST   = 16'(WAIT_MAX - 1);

  logic [0:0]  state;
  logic [15:0] wait_cnt;
  logic        rs1_hit;
  logic        rs2_hit;
  logic        luse;
  logic        memstall;

  // r0 is hardwired zero, so a load targeting it can never feed a consumer.
  assign rs1_hit = (id_rs1 != 4'd0) &&
                   ((ex1_is_load && (ex1_rd == id_rs1)) || (ex2_is_load && (ex2_rd == id_rs1)));
  assign rs2_hit = (id_rs2 != 4'd0) &&
                   ((ex1_is_load && (ex1_rd == id_rs2)) || (ex2_is_load && (ex2_rd == id_rs2)));
  assign luse     = (id_rs1_used && rs1_hit) || (id_rs2_used && rs2_hit);
  assign memstall = mem_req && !mem_ready;
  assign state_o  = state;

  // NOTE: every output gets a default first so no path through the priority chain infers a latch.
  always_comb begin
    pc_en         = 1'b1;
    if_id_en      = 1'b1;
    id_ex1_en     = 1'b1;
    ex1_ex2_en    = 1'b1;
    ex2_mem_en    = 1'b1;
    mem_wb_en     = 1'b1;
    if_id_flush   = 1'b0;
    id_ex1_flush  = 1'b0;
    ex1_ex2_flush = 1'b0;
    mem_wb_bubble = 1'b0;
    if (!rst) begin
      {pc_en, if_id_en, id_ex1_en, ex1_ex2_en, ex2_mem_en, mem_wb_en} = 6'b000000;
      {if_id_flush, id_ex1_flush, ex1_ex2_flush, mem_wb_bubble}     = 4'b1111;
    end else if (memstall) begin
      // Whole pipe freezes; WB retires a NOP while MEM waits.
      {pc_en, if_id_en, id_ex1_en, ex1_ex2_en, ex2_mem_en, mem_wb_en} = 6'b000000;
      mem_wb_bubble = 1'b1;
    end else if (ex2_branch_taken) begin
      if_id_flush   = 1'b1;
      id_ex1_flush  = 1'b1;
      ex1_ex2_flush = 1'b1;
    end else if (luse) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex1_flush = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= ST_RUN;
      wait_cnt    <= 16'd0;
      stall_count <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state <= memstall ? ST_MEM_WAIT : ST_RUN;
      if (memstall) begin
        if (wait_cnt != WAIT_TOP) wait_cnt <= wait_cnt + 16'd1;
        // The entry cycle counts as the first wait cycle, so WAIT_MAX stalled edges trip the watchdog.
        if (wait_cnt == WAIT_LAST) mem_timeout <= 1'b1;
      end else begin
        wait_cnt <= 16'd0;
      end
      if (!pc_en && (stall_count != {CNT_W{1'b1}})) stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: a default instance and a small one (WAIT_MAX=4, CNT_W=3) share stimulus.
module tb_pipe_hazard_ctrl;

  localparam logic [5:0] EN_ALL   = 6'b111111;
  localparam logic [5:0] EN_NONE  = 6'b000000;
  localparam logic [5:0] EN_LUSE  = 6'b001111;
  localparam logic [3:0] FL_NONE  = 4'b0000;
  localparam logic [3:0] FL_RESET = 4'b1111;
  localparam logic [3:0] FL_BR    = 4'b1110;
  localparam logic [3:0] FL_LUSE  = 4'b0100;
  localparam logic [3:0] FL_MEM   = 4'b0001;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] id_rs1, id_rs2, ex1_rd, ex2_rd;
  logic       id_rs1_used, id_rs2_used, ex1_is_load, ex2_is_load;
  logic       ex2_branch_taken, mem_req, mem_ready;

  logic        a_pc, a_ifid, a_idex1, a_ex1ex2, a_ex2mem, a_memwb;
  logic        a_f_ifid, a_f_idex1, a_f_ex1ex2, a_bub, a_tmo, a_st;
  logic [15:0] a_cnt;
  logic        b_pc, b_ifid, b_idex1, b_ex1ex2, b_ex2mem, b_memwb;
  logic        b_f_ifid, b_f_idex1, b_f_ex1ex2, b_bub, b_tmo, b_st;
  logic [2:0]  b_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl dut_a (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used),
    .id_rs2_used(id_rs2_used), .ex1_rd(ex1_rd), .ex1_is_load(ex1_is_load), .ex2_rd(ex2_rd),
    .ex2_is_load(ex2_is_load), .ex2_branch_taken(ex2_branch_taken), .mem_req(mem_req),
    .mem_ready(mem_ready), .pc_en(a_pc), .if_id_en(a_ifid), .id_ex1_en(a_idex1),
    .ex1_ex2_en(a_ex1ex2), .ex2_mem_en(a_ex2mem), .mem_wb_en(a_memwb), .if_id_flush(a_f_ifid),
    .id_ex1_flush(a_f_idex1), .ex1_ex2_flush(a_f_ex1ex2), .mem_wb_bubble(a_bub),
    .stall_count(a_cnt), .mem_timeout(a_tmo), .state_o(a_st)
  );

  pipe_hazard_ctrl #(.WAIT_MAX(4), .CNT_W(3)) dut_b (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used),
    .id_rs2_used(id_rs2_used), .ex1_rd(ex1_rd), .ex1_is_load(ex1_is_load), .ex2_rd(ex2_rd),
    .ex2_is_load(ex2_is_load), .ex2_branch_taken(ex2_branch_taken), .mem_req(mem_req),
    .mem_ready(mem_ready), .pc_en(b_pc), .if_id_en(b_ifid), .id_ex1_en(b_idex1),
    .ex1_ex2_en(b_ex1ex2), .ex2_mem_en(b_ex2mem), .mem_wb_en(b_memwb), .if_id_flush(b_f_ifid),
    .id_ex1_flush(b_f_idex1), .ex1_ex2_flush(b_f_ex1ex2), .mem_wb_bubble(b_bub),
    .stall_count(b_cnt), .mem_timeout(b_tmo), .state_o(b_st)
  );

  wire [5:0] a_en = {a_pc, a_ifid, a_idex1, a_ex1ex2, a_ex2mem, a_memwb};
  wire [3:0] a_fl = {a_f_ifid, a_f_idex1, a_f_ex1ex2, a_bub};
  wire [5:0] b_en = {b_pc, b_ifid, b_idex1, b_ex1ex2, b_ex2mem, b_memwb};
  wire [3:0] b_fl = {b_f_ifid, b_f_idex1, b_f_ex1ex2, b_bub};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    id_rs1 = 4'd0; id_rs2 = 4'd0; id_rs1_used = 1'b0; id_rs2_used = 1'b0;
    ex1_rd = 4'd0; ex1_is_load = 1'b0; ex2_rd = 4'd0; ex2_is_load = 1'b0;
    ex2_branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic rand_inputs();
    id_rs1 = 4'($urandom); id_rs2 = 4'($urandom); id_rs1_used = 1'($urandom);
    id_rs2_used = 1'($urandom); ex1_rd = 4'($urandom); ex1_is_load = 1'($urandom);
    ex2_rd = 4'($urandom); ex2_is_load = 1'($urandom); ex2_branch_taken = 1'($urandom);
    mem_req = 1'($urandom); mem_ready = 1'($urandom);
  endtask

  // Inputs change just after a falling edge; outputs are sampled 1 time unit later.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    step(); idle_inputs(); rst = 1'b0;
    step(); rst = 1'b1; #1;
  endtask

  task automatic check_both(input string tag, input logic [5:0] en, input logic [3:0] fl);
    check({tag, "_en_a"}, 32'(a_en), 32'(en));
    check({tag, "_fl_a"}, 32'(a_fl), 32'(fl));
    check({tag, "_en_b"}, 32'(b_en), 32'(en));
    check({tag, "_fl_b"}, 32'(b_fl), 32'(fl));
  endtask

  initial begin
    idle_inputs();
    rst = 1'b0;

    // Reset with random inputs for two cycles.
    step(); rand_inputs(); #1;
    check_both("rst0", EN_NONE, FL_RESET);
    step(); rand_inputs(); mem_req = 1'b1; mem_ready = 1'b0; #1;
    check_both("rst1", EN_NONE, FL_RESET);
    check("rst_cnt_a", 32'(a_cnt), 32'd0);
    check("rst_tmo_a", 32'(a_tmo), 32'd0);
    check("rst_st_a", 32'(a_st), 32'd0);
    check("rst_st_b", 32'(b_st), 32'd0);

    step(); idle_inputs(); rst = 1'b1; #1;
    check_both("idle", EN_ALL, FL_NONE);
    check("idle_st", 32'(a_st), 32'd0);
    check("idle_cnt", 32'(a_cnt), 32'd0);

    // Load-use: load in EX1, then the same load in EX2, then released.
    step(); ex1_is_load = 1'b1; ex1_rd = 4'd5; id_rs1 = 4'd5; id_rs1_used = 1'b1; #1;
    check_both("luse_ex1", EN_LUSE, FL_LUSE);
    step(); ex1_is_load = 1'b0; ex1_rd = 4'd0; ex2_is_load = 1'b1; ex2_rd = 4'd5; #1;
    check_both("luse_ex2", EN_LUSE, FL_LUSE);
    check("luse_cnt1", 32'(a_cnt), 32'd1);
    step(); ex2_is_load = 1'b0; ex2_rd = 4'd0; #1;
    check_both("luse_rel", EN_ALL, FL_NONE);
    check("luse_cnt2_a", 32'(a_cnt), 32'd2);
    check("luse_cnt2_b", 32'(b_cnt), 32'd2);

    // r0 never hazards; an unused source never hazards; the same source used does.
    step(); ex1_is_load = 1'b1; ex1_rd = 4'd0; id_rs1 = 4'd0; id_rs1_used = 1'b1; #1;
    check_both("r0", EN_ALL, FL_NONE);
    step(); ex1_rd = 4'd3; id_rs1 = 4'd7; id_rs2 = 4'd3; id_rs2_used = 1'b0; #1;
    check_both("rs2_unused", EN_ALL, FL_NONE);
    step(); id_rs2_used = 1'b1; #1;
    check_both("rs2_used", EN_LUSE, FL_LUSE);

    // Taken branch overrides a load-use match; counter does not move.
    step(); idle_inputs(); ex2_branch_taken = 1'b1;
    ex1_is_load = 1'b1; ex1_rd = 4'd5; id_rs1 = 4'd5; id_rs1_used = 1'b1; #1;
    check_both("branch", EN_ALL, FL_BR);
    check("branch_cnt_pre", 32'(a_cnt), 32'd3);
    step(); idle_inputs(); #1;
    check("branch_cnt_post", 32'(a_cnt), 32'd3);

    // Three-cycle memory wait, then ready.
    do_reset();
    check("mw_cnt0", 32'(a_cnt), 32'd0);
    mem_req = 1'b1; mem_ready = 1'b0; #1;
    check_both("mw_c1", EN_NONE, FL_MEM);
    check("mw_c1_st", 32'(a_st), 32'd0);
    step(); #1;
    check_both("mw_c2", EN_NONE, FL_MEM);
    check("mw_c2_st", 32'(a_st), 32'd1);
    step(); #1;
    check_both("mw_c3", EN_NONE, FL_MEM);
    check("mw_c3_cnt", 32'(a_cnt), 32'd2);
    step(); mem_ready = 1'b1; #1;
    check_both("mw_ready", EN_ALL, FL_NONE);
    check("mw_ready_st", 32'(a_st), 32'd1);
    check("mw_ready_cnt_a", 32'(a_cnt), 32'd3);
    step(); idle_inputs(); #1;
    check("mw_done_st", 32'(a_st), 32'd0);
    check("mw_done_cnt_b", 32'(b_cnt), 32'd3);
    check("mw_done_tmo_b", 32'(b_tmo), 32'd0);

    // Watchdog: six wait cycles trip the small instance after the fourth.
    do_reset();
    mem_req = 1'b1; mem_ready = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      #1;
      check($sformatf("tmo_c%0d_b", c), 32'(b_tmo), (c >= 5) ? 32'd1 : 32'd0);
      check($sformatf("tmo_c%0d_a", c), 32'(a_tmo), 32'd0);
      step();
    end
    // Release cycle with a load-use: normal rules apply in the same cycle.
    mem_ready = 1'b1; ex1_is_load = 1'b1; ex1_rd = 4'd9; id_rs1 = 4'd9; id_rs1_used = 1'b1; #1;
    check_both("tmo_rel", EN_LUSE, FL_LUSE);
    check("tmo_rel_st", 32'(b_st), 32'd1);
    step(); idle_inputs(); #1;
    check("tmo_sticky_b", 32'(b_tmo), 32'd1);
    check("tmo_st_run", 32'(b_st), 32'd0);
    check("tmo_cnt_a", 32'(a_cnt), 32'd7);
    check("tmo_cnt_b", 32'(b_cnt), 32'd7);

    // Ten more stalled cycles: small counter saturates, wide one keeps counting.
    mem_req = 1'b1; mem_ready = 1'b0;
    for (int c = 0; c < 10; c++) step();
    idle_inputs(); #1;
    check("sat_cnt_b", 32'(b_cnt), 32'd7);
    check("sat_cnt_a", 32'(a_cnt), 32'd17);
    check("sat_tmo_b", 32'(b_tmo), 32'd1);
    check("sat_tmo_a", 32'(a_tmo), 32'd0);
    step(); #1;
    check("sat_hold_b", 32'(b_cnt), 32'd7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
